// File: rtl/idle_config_ctrl.sv
// IDLE-state settings controller for the Simon top FSM: registers and saturates mode/level/speed, debounces start, freezes on lock.
// Settings reach the outputs one cycle after sampling; o_done follows the last debounce sample by one cycle; no backpressure.
module idle_config_ctrl #(
  parameter int MODE_W          = 2,
  parameter int LEVEL_W         = 3,
  parameter int SPEED_W         = 2,
  parameter int MAX_LEVEL       = 3,
  parameter int DEFAULT_MODE    = 0,
  parameter int DEFAULT_LEVEL   = 0,
  parameter int DEFAULT_SPEED   = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic [SPEED_W-1:0] i_speed,
  output logic [MODE_W-1:0]  o_mode,
  output logic [LEVEL_W-1:0] o_level,
  output logic [SPEED_W-1:0] o_speed,
  output logic [2:0]         o_changed,
  output logic               o_active,
  output logic               o_done,
  output logic               o_locked,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_CONFIG   = 2'b01,
    ST_DEBOUNCE = 2'b10,
    ST_LOCKED   = 2'b11
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [2:0]         changed_q, changed_d;
  logic               done_q, done_d;
  logic [LEVEL_W-1:0] level_sat;
  logic               start_rise;

  assign level_sat  = (i_level > LEVEL_MAX) ? LEVEL_MAX : i_level;
  assign start_rise = i_start & ~start_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    level_d   = level_q;
    speed_d   = speed_q;
    changed_d = 3'b000;
    done_d    = 1'b0;

    // Enable drop overrides everything, including a debounce completing this cycle.
    if (!i_enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_CONFIG;
        end
        ST_CONFIG: begin
          mode_d    = i_mode;
          level_d   = level_sat;
          speed_d   = i_speed;
          changed_d = {speed_d != speed_q, level_d != level_q, mode_d != mode_q};
          if (start_rise) begin
            if (DEBOUNCE_CYCLES > 1) begin
              state_d = ST_DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end else begin
              state_d = ST_LOCKED;
              done_d  = 1'b1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (i_start) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_LOCKED;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_CONFIG;
            cnt_d   = '0;
          end
        end
        ST_LOCKED: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      start_q   <= 1'b1;
      mode_q    <= MODE_W'(DEFAULT_MODE);
      level_q   <= LEVEL_W'(DEFAULT_LEVEL);
      speed_q   <= SPEED_W'(DEFAULT_SPEED);
      changed_q <= 3'b000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= i_start;
      mode_q    <= mode_d;
      level_q   <= level_d;
      speed_q   <= speed_d;
      changed_q <= changed_d;
      done_q    <= done_d;
    end
  end

  assign o_mode    = mode_q;
  assign o_level   = level_q;
  assign o_speed   = speed_q;
  assign o_changed = changed_q;
  assign o_done    = done_q;
  assign o_active  = (state_q == ST_CONFIG) || (state_q == ST_DEBOUNCE);
  assign o_locked  = (state_q == ST_LOCKED);
  assign o_state   = state_q;

endmodule

// File: tb/tb_idle_config_ctrl.sv
// Directed bench: default build (4-sample debounce, MAX_LEVEL 3) plus a single-sample debounce build.
module tb_idle_config_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_en, a_start, b_en, b_start;
  logic [1:0] mode_in, speed_in;
  logic [2:0] level_in;

  logic [1:0] a_mode, a_speed, a_state, b_mode, b_speed, b_state;
  logic [2:0] a_level, a_changed, b_level, b_changed;
  logic       a_active, a_done, a_locked, b_active, b_done, b_locked;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  idle_config_ctrl u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(a_en), .i_start(a_start),
    .i_mode(mode_in), .i_level(level_in), .i_speed(speed_in),
    .o_mode(a_mode), .o_level(a_level), .o_speed(a_speed), .o_changed(a_changed),
    .o_active(a_active), .o_done(a_done), .o_locked(a_locked), .o_state(a_state)
  );

  idle_config_ctrl #(.DEBOUNCE_CYCLES(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(b_en), .i_start(b_start),
    .i_mode(mode_in), .i_level(level_in), .i_speed(speed_in),
    .o_mode(b_mode), .o_level(b_level), .o_speed(b_speed), .o_changed(b_changed),
    .o_active(b_active), .o_done(b_done), .o_locked(b_locked), .o_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_en = 1'b1; a_start = 1'b1; b_en = 1'b1; b_start = 1'b1;
    mode_in = 2'd3; level_in = 3'd7; speed_in = 2'd2;

    for (int i = 0; i < 3; i++) begin
      mode_in  = 2'($urandom_range(3));
      level_in = 3'($urandom_range(7));
      speed_in = 2'($urandom_range(3));
      step();
    end
    check("rst_state", a_state, 0);
    check("rst_mode", a_mode, 0);
    check("rst_level", a_level, 0);
    check("rst_speed", a_speed, 0);
    check("rst_done", a_done, 0);
    check("rst_active", a_active, 0);
    check("rst_locked", a_locked, 0);
    check("rst_changed", a_changed, 0);
    check("rst_b_state", b_state, 0);

    rst_n = 1'b1; mode_in = 2'd0; level_in = 3'd0; speed_in = 2'd0;
    step();
    check("rel_state", a_state, 1);
    check("rel_active", a_active, 1);
    check("rel_b_state", b_state, 1);
    step();
    check("rel_changed", a_changed, 0);
    step();
    check("no_edge_state", a_state, 1);
    check("no_edge_b_state", b_state, 1);

    mode_in = 2'd2;
    step();
    check("mode_val", a_mode, 2);
    check("mode_pulse", a_changed, 3'b001);
    step();
    check("mode_pulse_end", a_changed, 0);
    level_in = 3'd6;
    step();
    check("level_sat", a_level, 3);
    check("level_pulse", a_changed, 3'b010);
    level_in = 3'd5;
    step();
    check("level_sat_hold", a_level, 3);
    check("level_no_pulse", a_changed, 0);
    speed_in = 2'd1;
    step();
    check("speed_val", a_speed, 1);
    check("speed_pulse", a_changed, 3'b100);

    a_start = 1'b0; b_start = 1'b0;
    step();
    check("pre_deb_state", a_state, 1);
    a_start = 1'b1; b_start = 1'b1;
    step();
    check("deb1_state", a_state, 2);
    check("b_lock_state", b_state, 3);
    check("b_lock_done", b_done, 1);
    step();
    check("deb2_state", a_state, 2);
    check("b_done_end", b_done, 0);
    check("b_locked", b_locked, 1);
    step();
    check("deb3_state", a_state, 2);
    check("deb3_done", a_done, 0);
    step();
    check("lock_state", a_state, 3);
    check("lock_done", a_done, 1);
    check("lock_locked", a_locked, 1);
    check("lock_active", a_active, 0);
    step();
    check("lock_done_end", a_done, 0);
    check("lock_locked2", a_locked, 1);

    mode_in = 2'd1; level_in = 3'd0; speed_in = 2'd3;
    for (int i = 0; i < 4; i++) begin
      a_start = (i % 2) != 0;
      step();
      check("frz_mode", a_mode, 2);
      check("frz_level", a_level, 3);
      check("frz_speed", a_speed, 1);
      check("frz_changed", a_changed, 0);
      check("frz_done", a_done, 0);
      check("frz_state", a_state, 3);
    end

    a_en = 1'b0;
    step();
    check("dis_state", a_state, 0);
    check("dis_locked", a_locked, 0);
    check("dis_active", a_active, 0);
    check("dis_mode", a_mode, 2);
    check("dis_level", a_level, 3);

    mode_in = 2'd2; level_in = 3'd3; speed_in = 2'd1; a_start = 1'b0; a_en = 1'b1;
    step();
    check("re_state", a_state, 1);
    step();
    check("re_changed", a_changed, 0);
    a_start = 1'b1;
    step();
    check("glitch_deb1", a_state, 2);
    step();
    check("glitch_deb2", a_state, 2);
    a_start = 1'b0;
    step();
    check("glitch_back", a_state, 1);
    check("glitch_done", a_done, 0);
    a_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("relock_deb", a_state, 2);
    end
    step();
    check("relock_state", a_state, 3);
    check("relock_done", a_done, 1);

    a_en = 1'b0;
    step();
    a_en = 1'b1; a_start = 1'b0;
    step();
    check("race_cfg", a_state, 1);
    step();
    a_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("race_deb", a_state, 2);
    end
    a_en = 1'b0;
    step();
    check("race_state", a_state, 0);
    check("race_done", a_done, 0);
    step();
    check("race_done2", a_done, 0);

    a_en = 1'b1;
    step();
    check("rearm_cfg", a_state, 1);
    step();
    step();
    check("rearm_hold", a_state, 1);

    a_start = 1'b0;
    step();
    a_start = 1'b1;
    step();
    check("midrst_deb", a_state, 2);
    rst_n = 1'b0;
    step();
    check("midrst_state", a_state, 0);
    check("midrst_mode", a_mode, 0);
    check("midrst_level", a_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
